// File: rtl/bus_capture_fifo_if.sv
// Bus-capture FIFO interface.
// Groups the tristate-bus sample inputs, the consumer handshake and the status
// outputs of bus_capture_fifo.
//   master : drives DBusBuf/QEna/Strobe/DReady/OvfClr, observes results
//   slave  : the capture FIFO itself
interface bus_capture_fifo_if #(
  parameter int DHiBit   = 7,
  parameter int AddrBits = 2
);
  logic [DHiBit:0]   DBusBuf;
  logic [DHiBit:0]   QEna;
  logic              Strobe;
  logic              DReady;
  logic              OvfClr;
  logic [DHiBit:0]   DOut;
  logic              DPartial;
  logic              DValid;
  logic              Full;
  logic [AddrBits:0] Count;
  logic              Overflow;

  modport master (
    output DBusBuf, QEna, Strobe, DReady, OvfClr,
    input  DOut, DPartial, DValid, Full, Count, Overflow
  );

  modport slave (
    input  DBusBuf, QEna, Strobe, DReady, OvfClr,
    output DOut, DPartial, DValid, Full, Count, Overflow
  );
endinterface

// File: rtl/bus_capture_fifo.sv
// Bus capture FIFO.
// Samples the inverted, per-bit-enabled register bus on Strobe, restores true
// polarity, zeroes undriven bits, tags words captured under a partial mask and
// queues them in a 2**AddrBits deep first-word-fall-through FIFO.
// Ports:
//   Clk  - rising-edge clock
//   Rst  - synchronous active-low reset
//   bus  - bus_capture_fifo_if.slave: DBusBuf, QEna, Strobe, DReady, OvfClr in;
//          DOut, DPartial, DValid, Full, Count, Overflow out

// One bus bit: undriven bits are forced to 0 so x/z never reaches storage.
module bus_capture_lane (
  input  logic dbus,
  input  logic ena,
  output logic cap
);
  assign cap = ena ? ~dbus : 1'b0;
endmodule

module bus_capture_fifo #(
  parameter int DHiBit   = 7,
  parameter int AddrBits = 2
) (
  input logic              Clk,
  input logic              Rst,
  bus_capture_fifo_if.slave bus
);
  localparam int Depth = 2 ** AddrBits;

  typedef struct packed {
    logic            partial;
    logic [DHiBit:0] data;
  } entry_t;

  entry_t              mem [Depth];
  logic [AddrBits-1:0] wr_ptr, rd_ptr;
  logic [AddrBits:0]   count;
  logic                overflow;
  logic [DHiBit:0]     cap_data;
  logic                full, dvalid, push, pop, drop;

  for (genvar i = 0; i <= DHiBit; i++) begin : g_lane
    bus_capture_lane u_lane (
      .dbus (bus.DBusBuf[i]),
      .ena  (bus.QEna[i]),
      .cap  (cap_data[i])
    );
  end

  assign full   = (count == (AddrBits+1)'(Depth));
  assign dvalid = (count != '0);
  assign pop    = bus.DReady & dvalid;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push   = bus.Strobe & (~full | pop);
  assign drop   = bus.Strobe & full & ~pop;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      // Drop beats clear so a loss on the clearing edge is never hidden.
      if (drop)            overflow <= 1'b1;
      else if (bus.OvfClr) overflow <= 1'b0;
    end
  end

  // Storage needs no reset; the read side is masked while empty.
  always_ff @(posedge Clk) begin
    if (Rst && push) mem[wr_ptr] <= '{partial: ~&bus.QEna, data: cap_data};
  end

  assign bus.DOut     = dvalid ? mem[rd_ptr].data : '0;
  assign bus.DPartial = dvalid & mem[rd_ptr].partial;
  assign bus.DValid   = dvalid;
  assign bus.Full     = full;
  assign bus.Count    = count;
  assign bus.Overflow = overflow;
endmodule

// File: tb/tb_bus_capture_fifo.sv
module tb_bus_capture_fifo;
  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  bus_capture_fifo_if #(.DHiBit(7), .AddrBits(2)) bus ();

  bus_capture_fifo #(.DHiBit(7), .AddrBits(2)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [7:0] data;
    logic       partial;
  } exp_t;

  typedef struct {
    logic [7:0] qena;
    logic [7:0] dbus;
    logic [7:0] exp_data;
    logic       exp_partial;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Single-cycle capture; the model value is queued as the strobe is driven.
  task automatic capture(input logic [7:0] qena, input logic [7:0] dbus,
                         input bit expect_push);
    logic [7:0] d;
    d = dbus;
    for (int b = 0; b < 8; b++) if (!qena[b]) d[b] = 1'bz;
    bus.QEna    = qena;
    bus.DBusBuf = d;
    bus.Strobe  = 1'b1;
    if (expect_push) sb.push_back('{data: ~dbus & qena, partial: ~&qena});
    tick();
    bus.Strobe  = 1'b0;
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({name, "_valid"},   bus.DValid,   1'b1);
    chk({name, "_data"},    bus.DOut,     e.data);
    chk({name, "_partial"}, bus.DPartial, e.partial);
    bus.DReady = 1'b1;
    tick();
    bus.DReady = 1'b0;
  endtask

  initial begin
    bus.DBusBuf = '0; bus.QEna = '0; bus.Strobe = 0; bus.DReady = 0; bus.OvfClr = 0;

    vecs[0] = '{8'hFF, 8'h88, 8'h77, 1'b0};
    vecs[1] = '{8'h0E, 8'hF1, 8'h0E, 1'b1};
    vecs[2] = '{8'h00, 8'hAA, 8'h00, 1'b1};
    vecs[3] = '{8'hF0, 8'h0F, 8'hF0, 1'b1};
    vecs[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0};

    // Reset, held with Strobe active to show reset priority.
    bus.Strobe = 1'b1;
    tick(); tick();
    bus.Strobe = 1'b0;
    chk("rst_count", bus.Count, 0);
    chk("rst_valid", bus.DValid, 0);
    chk("rst_full",  bus.Full, 0);
    chk("rst_ovf",   bus.Overflow, 0);
    chk("rst_dout",  bus.DOut, 0);
    Rst = 1'b1;
    tick();

    // Capture table: one word in, one word out.
    for (int i = 0; i < 5; i++) begin
      capture(vecs[i].qena, vecs[i].dbus, 1'b1);
      chk($sformatf("vec%0d_count", i), bus.Count, 1);
      chk($sformatf("vec%0d_data", i), bus.DOut, vecs[i].exp_data);
      chk($sformatf("vec%0d_partial", i), bus.DPartial, vecs[i].exp_partial);
      pop_check($sformatf("vec%0d_pop", i));
      chk($sformatf("vec%0d_empty", i), bus.DValid, 0);
      chk($sformatf("vec%0d_count0", i), bus.Count, 0);
    end

    // Fill to full, fifth strobe dropped.
    for (int k = 1; k <= 5; k++) begin
      capture(8'hFF, ~8'(k), k <= 4);
      if (k == 4) begin
        chk("fill_full", bus.Full, 1);
        chk("fill_count", bus.Count, 4);
        chk("fill_noovf", bus.Overflow, 0);
      end
    end
    chk("drop_ovf", bus.Overflow, 1);
    chk("drop_count", bus.Count, 4);
    for (int k = 0; k < 4; k++) pop_check($sformatf("drain%0d", k));
    chk("drain_empty", bus.DValid, 0);
    // Underflow attempt: pointers and count must not move.
    bus.DReady = 1'b1; tick(); bus.DReady = 1'b0;
    chk("underflow_count", bus.Count, 0);

    // Refill 2, then drain.
    capture(8'hFF, 8'hC3, 1'b1);
    capture(8'hFF, 8'h3C, 1'b1);
    pop_check("refill0");
    pop_check("refill1");

    // Overflow clear alone.
    bus.OvfClr = 1'b1; tick(); bus.OvfClr = 1'b0;
    chk("ovfclr_alone", bus.Overflow, 0);

    // Fill across the pointer wrap, then simultaneous push/pop while full.
    for (int k = 0; k < 4; k++) capture(8'hFF, ~(8'h10 + 8'(k)), 1'b1);
    chk("wrap_full", bus.Full, 1);
    chk("sim_head", bus.DOut, sb[0].data);
    void'(sb.pop_front());
    bus.DReady = 1'b1;
    capture(8'hFF, ~8'hAA, 1'b1);
    bus.DReady = 1'b0;
    chk("sim_count", bus.Count, 4);
    chk("sim_ovf", bus.Overflow, 0);
    chk("sim_newhead", bus.DOut, 8'h11);

    // Drop with clear on the same edge: drop wins.
    bus.OvfClr = 1'b1;
    capture(8'hFF, 8'h00, 1'b0);
    bus.OvfClr = 1'b0;
    chk("clr_vs_drop", bus.Overflow, 1);
    chk("clr_vs_drop_count", bus.Count, 4);
    for (int k = 0; k < 4; k++) pop_check($sformatf("simdrain%0d", k));
    chk("simdrain_empty", bus.DValid, 0);
    bus.OvfClr = 1'b1; tick(); bus.OvfClr = 1'b0;
    chk("ovfclr2", bus.Overflow, 0);

    // Mid-operation reset at Count=3 with Strobe on the same edge.
    for (int k = 0; k < 4; k++) capture(8'hFF, ~(8'h20 + 8'(k)), 1'b1);
    capture(8'hFF, 8'h00, 1'b0);
    pop_check("pre_rst");
    chk("pre_rst_count", bus.Count, 3);
    chk("pre_rst_ovf", bus.Overflow, 1);
    Rst = 1'b0;
    bus.Strobe = 1'b1; bus.DBusBuf = 8'h00; bus.QEna = 8'hFF;
    tick();
    bus.Strobe = 1'b0;
    Rst = 1'b1;
    sb.delete();
    chk("midrst_count", bus.Count, 0);
    chk("midrst_valid", bus.DValid, 0);
    chk("midrst_ovf", bus.Overflow, 0);
    capture(8'hFF, ~8'h5A, 1'b1);
    chk("post_rst_count", bus.Count, 1);
    pop_check("post_rst");
    chk("post_rst_empty", bus.DValid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bus_capture_fifo.md
Name: bus_capture_fifo

Overview:
- Downstream receiver for the per-bit tristate-buffered register bus.
- That bus drives inverted register data and is gated by a per-bit enable mask.
- This block samples the bus on a strobe, restores true polarity and forces undriven bits to 0.
- Each captured word is tagged, pushed into a small FIFO, and presented to the consumer through a valid/ready handshake.

Parameters:
- DHiBit, 7, MSB index of the data bus; bus width is DHiBit+1.
- AddrBits, 2, FIFO address width; depth is 2**AddrBits (default 4 entries).

Ports:
- Clk  input  1  rising-edge clock; all state changes on posedge Clk.
- Rst  input  1  reset, synchronous, active-low (asserted when 0, sampled at posedge Clk).
- DBusBuf  input  DHiBit+1  inverted buffered bus; bit i is meaningful only when QEna[i]=1.
- QEna  input  DHiBit+1  per-bit drive-enable mask, the same mask applied to the bus drivers.
- Strobe  input  1  capture request; samples the bus on this edge.
- DReady  input  1  consumer accepts DOut this cycle.
- DOut  output  DHiBit+1  head-of-FIFO data, true polarity.
- DPartial  output  1  head word was captured with QEna not all-ones.
- DValid  output  1  FIFO non-empty; DOut and DPartial are valid.
- Full  output  1  FIFO holds 2**AddrBits entries.
- Count  output  AddrBits+1  current occupancy, 0..2**AddrBits.
- Overflow  output  1  sticky flag: a capture was dropped.
- OvfClr  input  1  clears Overflow.

Behaviour:
- Reset (Rst=0 at posedge Clk):
  - Count=0, DValid=0, Full=0, Overflow=0, DOut=0, DPartial=0; read and write pointers = 0.
  - Reset takes priority over Strobe, DReady and OvfClr on the same edge.
  - Mid-operation reset discards all stored words.
- Capture word: CapData[i] = QEna[i] ? ~DBusBuf[i] : 1'b0. CapPartial = ~&QEna.
  - x/z on disabled bits never reaches storage.
- Push: occurs at a posedge with Strobe=1 and (Full=0 or pop in the same cycle).
  - Writes {CapPartial, CapData} at the write pointer; write pointer increments modulo depth.
- Pop: occurs at a posedge with DReady=1 and DValid=1.
  - Read pointer increments modulo depth.
  - DReady with DValid=0 is ignored; no underflow, pointers unchanged.
- Simultaneous push and pop:
  - Both take effect; Count unchanged.
  - This applies when Full=1 as well: no drop.
  - When Count=0 only a push is possible; the pop is ignored.
- Drop: Strobe=1, Full=1, no pop in the same cycle.
  - The word is discarded; Overflow<=1 and stays set.
  - Overflow clears only when OvfClr=1 and no new drop occurs that edge; a drop wins over clear.
- Count updates every edge: +1 on push only, -1 on pop only, unchanged otherwise. Full=(Count==2**AddrBits). DValid=(Count!=0).
- Latency:
  - A word captured at edge N appears on DOut with DValid=1 after edge N (visible in cycle N+1) when the FIFO was empty.
  - DOut/DPartial are driven from storage at the read pointer (first-word-fall-through). They hold the head word while DValid=1 and DReady=0.
- Pointer wrap-around is modulo 2**AddrBits; Count distinguishes full from empty.
- Outputs are registered or decoded from registers only; no combinational path from Strobe or DReady to any output.

Test Plan:
- Reset/basic capture: hold Rst=0 for 2 edges -> Count=0, DValid=0, Overflow=0. Release; QEna=8'hFF, DBusBuf=8'h88, Strobe for 1 cycle -> next cycle DValid=1, DOut=8'h77, DPartial=0, Count=1. DReady for 1 cycle -> DValid=0, Count=0.
- Masking: QEna=8'h0E, DBusBuf=8'hzz on bits with QEna=0 and 8'hF1 elsewhere, Strobe -> DOut=8'h0E, DPartial=1.
- Fill, overflow and wrap:
  - 5 consecutive strobes with DBusBuf=~8'h01..~8'h05, QEna=8'hFF, DReady=0 -> Full=1 after the 4th, Count=4, 5th word dropped, Overflow=1.
  - Drain -> DOut sequence 01,02,03,04.
  - Refill 2 words -> read 2 words correctly across the pointer wrap.
- Simultaneous push/pop when full: Count=4, Strobe=1 and DReady=1 on the same edge with data 8'hAA -> Count stays 4, Overflow stays 0, 8'hAA is read last after draining.
- Overflow clear priority: Overflow=1; OvfClr=1 alone -> Overflow=0. OvfClr=1 together with a drop -> Overflow=1.
- Mid-operation reset: Count=3, Strobe=1 and Rst=0 on the same edge -> Count=0, DValid=0, Overflow=0; next capture returns only the new word.
